// File: rtl/aes_128_pkg.sv
// Shared AES-128 tables, key-schedule FSM encoding and word helpers.
package aes_128_pkg;

    // Forward S-box, entry 0 in the most significant byte
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants for rounds 1..10, entry 0 is round 1
    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_SUB   = 2'd2,
        ST_UPD   = 2'd3
    } key_state_t;

    // Single-byte S-box lookup
    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Rcon for the round that follows round index idx (0..9); zero outside range
    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx < 4'd10) r = RCON[idx];
        return r;
    endfunction

    // RotWord(a,b,c,d) = (b,c,d,a)
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Chained XOR producing the next round key from the current one and t
    function automatic logic [127:0] key_step(input logic [127:0] key, input logic [31:0] t);
        logic [31:0] w0, w1, w2, w3;
        w0 = key[127:96] ^ t;
        w1 = key[95:64]  ^ w0;
        w2 = key[63:32]  ^ w1;
        w3 = key[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_128_sbox_word.sv
// Four parallel S-box lookups with a registered 32-bit result.
module aes_128_sbox_word
    import aes_128_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    input  logic [31:0] word_in,
    output logic [31:0] sub_word
);

    // Capture SubWord(word_in) when enabled; holds otherwise
    always_ff @(posedge clk) begin
        if (en) begin
            sub_word <= {sbox_byte(word_in[31:24]), sbox_byte(word_in[23:16]),
                         sbox_byte(word_in[15:8]),  sbox_byte(word_in[7:0])};
        end
    end

endmodule

// File: rtl/aes_128_key_expand.sv
// Iterative AES-128 key schedule: one round key per request, 2-cycle step.
module aes_128_key_expand
    import aes_128_pkg::*;
#(
    parameter int unsigned NR = 10
)
(
    input  logic         clk,
    input  logic         kill,
    input  logic         en,
    input  logic [127:0] key_in,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         key_valid,
    output logic         last
);

    key_state_t   state;
    logic         sbox_en_c;
    logic [31:0]  rot_w3_c;
    logic [31:0]  sub_word;
    logic [31:0]  t_c;
    logic [127:0] new_key_c;

    // S-box input is RotWord(w3); it is only captured while in SUB
    always_comb begin
        sbox_en_c = (state == ST_SUB);
        rot_w3_c  = rot_word(round_key[31:0]);
        t_c       = sub_word ^ {rcon_byte(round_num), 24'h000000};
        new_key_c = key_step(round_key, t_c);
    end

    aes_128_sbox_word u_sbox (
        .clk      (clk),
        .en       (sbox_en_c),
        .word_in  (rot_w3_c),
        .sub_word (sub_word)
    );

    // Control FSM and output registers; kill beats en, en beats next
    always_ff @(posedge clk) begin
        if (kill) begin
            state     <= ST_IDLE;
            round_key <= '0;
            round_num <= '0;
            key_valid <= 1'b0;
            last      <= 1'b0;
        end else if (en) begin
            state     <= ST_READY;
            round_key <= key_in;
            round_num <= '0;
            key_valid <= 1'b1;
            last      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    key_valid <= 1'b0;
                end
                ST_READY: begin
                    if (next && (round_num < 4'(NR))) begin
                        state     <= ST_SUB;
                        key_valid <= 1'b0;
                    end
                end
                ST_SUB: begin
                    state <= ST_UPD;
                end
                ST_UPD: begin
                    state     <= ST_READY;
                    round_key <= new_key_c;
                    round_num <= round_num + 4'd1;
                    key_valid <= 1'b1;
                    last      <= (round_num == 4'(NR - 1));
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_key_expand.sv
// Directed bench for the iterative AES-128 key schedule.
module tb_aes_128_key_expand;

    localparam int unsigned NR = 10;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_R3 = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] KEY_A_R4 = 128'hef44a541a8525b7fb671253bdb0bad00;
    localparam logic [127:0] KEY_A_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY_B_RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk;
    logic         kill;
    logic         en;
    logic [127:0] key_in;
    logic         next;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         last;

    int vectors;
    int miscompares;

    aes_128_key_expand #(.NR(NR)) dut (
        .clk       (clk),
        .kill      (kill),
        .en        (en),
        .key_in    (key_in),
        .next      (next),
        .round_key (round_key),
        .round_num (round_num),
        .key_valid (key_valid),
        .last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Load a key and confirm round 0 is presented on the next cycle
    task automatic load_key(input logic [127:0] k);
        en = 1'b1;
        key_in = k;
        tick();
        en = 1'b0;
        vectors++;
        if (key_valid !== 1'b1 || round_num !== 4'd0 || round_key !== k || last !== 1'b0) begin
            miscompares++;
            $display("FAIL load: valid=%b num=%0d key=%h last=%b, want 1 0 %h 0",
                     key_valid, round_num, round_key, last, k);
        end
    endtask

    // Request one step; key_valid must drop for exactly two cycles
    task automatic advance(input int r);
        next = 1'b1;
        tick();
        next = 1'b0;
        vectors++;
        if (key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL step%0d_gap1: key_valid=%b want 0", r, key_valid);
        end
        tick();
        vectors++;
        if (key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL step%0d_gap2: key_valid=%b want 0", r, key_valid);
        end
        tick();
        vectors++;
        if (key_valid !== 1'b1 || round_num !== 4'(r) || last !== (r == NR)) begin
            miscompares++;
            $display("FAIL step%0d: valid=%b num=%0d last=%b want 1 %0d %b",
                     r, key_valid, round_num, last, r, (r == NR));
        end
    endtask

    task automatic test_reset;
        kill = 1'b1;
        en = 1'b0;
        next = 1'b0;
        key_in = '0;
        repeat (5) tick();
        kill = 1'b0;
        tick();
        vectors++;
        if (round_key !== 128'h0 || round_num !== 4'd0 || key_valid !== 1'b0 || last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: key=%h num=%0d valid=%b last=%b want all zero",
                     round_key, round_num, key_valid, last);
        end
    endtask

    task automatic test_fips_key;
        load_key(KEY_A);
        for (int r = 1; r <= 10; r++) begin
            advance(r);
            if (r == 1) begin
                vectors++;
                if (round_key !== KEY_A_R1) begin
                    miscompares++;
                    $display("FAIL fips_r1: key=%h want %h", round_key, KEY_A_R1);
                end
            end
            if (r == 10) begin
                vectors++;
                if (round_key !== KEY_A_RA) begin
                    miscompares++;
                    $display("FAIL fips_r10: key=%h want %h", round_key, KEY_A_RA);
                end
            end
        end
    endtask

    task automatic test_hold_last;
        for (int i = 0; i < 3; i++) begin
            next = 1'b1;
            tick();
            next = 1'b0;
            tick();
            vectors++;
            if (round_key !== KEY_A_RA || round_num !== 4'd10 || last !== 1'b1 || key_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_last%0d: key=%h num=%0d last=%b valid=%b want %h 10 1 1",
                         i, round_key, round_num, last, key_valid, KEY_A_RA);
            end
        end
    endtask

    task automatic test_ascending_key;
        load_key(KEY_B);
        for (int r = 1; r <= 10; r++) begin
            advance(r);
            if (r == 1) begin
                vectors++;
                if (round_key !== KEY_B_R1) begin
                    miscompares++;
                    $display("FAIL asc_r1: key=%h want %h", round_key, KEY_B_R1);
                end
            end
            if (r == 10) begin
                vectors++;
                if (round_key !== KEY_B_RA) begin
                    miscompares++;
                    $display("FAIL asc_r10: key=%h want %h", round_key, KEY_B_RA);
                end
            end
        end
    endtask

    task automatic test_restart_in_sub;
        load_key(KEY_A);
        for (int r = 1; r <= 4; r++) advance(r);
        vectors++;
        if (round_key !== KEY_A_R4) begin
            miscompares++;
            $display("FAIL restart_r4: key=%h want %h", round_key, KEY_A_R4);
        end
        next = 1'b1;
        tick();
        next = 1'b0;
        en = 1'b1;
        key_in = KEY_B;
        tick();
        en = 1'b0;
        vectors++;
        if (key_valid !== 1'b1 || round_num !== 4'd0 || round_key !== KEY_B) begin
            miscompares++;
            $display("FAIL restart_load: valid=%b num=%0d key=%h want 1 0 %h",
                     key_valid, round_num, round_key, KEY_B);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (key_valid !== 1'b1 || round_num !== 4'd0 || round_key !== KEY_B) begin
                miscompares++;
                $display("FAIL restart_hold%0d: valid=%b num=%0d key=%h want 1 0 %h",
                         i, key_valid, round_num, round_key, KEY_B);
            end
        end
    endtask

    task automatic test_en_next_same;
        load_key(KEY_A);
        for (int r = 1; r <= 3; r++) advance(r);
        vectors++;
        if (round_key !== KEY_A_R3) begin
            miscompares++;
            $display("FAIL same_r3: key=%h want %h", round_key, KEY_A_R3);
        end
        en = 1'b1;
        next = 1'b1;
        key_in = KEY_B;
        tick();
        en = 1'b0;
        next = 1'b0;
        vectors++;
        if (key_valid !== 1'b1 || round_num !== 4'd0 || round_key !== KEY_B) begin
            miscompares++;
            $display("FAIL same_load: valid=%b num=%0d key=%h want 1 0 %h",
                     key_valid, round_num, round_key, KEY_B);
        end
        tick();
        vectors++;
        if (key_valid !== 1'b1 || round_num !== 4'd0) begin
            miscompares++;
            $display("FAIL same_drop: valid=%b num=%0d want 1 0", key_valid, round_num);
        end
    endtask

    task automatic test_kill_upd;
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        vectors++;
        if (round_key !== 128'h0 || round_num !== 4'd0 || key_valid !== 1'b0 || last !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_upd: key=%h num=%0d valid=%b last=%b want all zero",
                     round_key, round_num, key_valid, last);
        end
        next = 1'b1;
        tick();
        next = 1'b0;
        repeat (3) tick();
        vectors++;
        if (key_valid !== 1'b0 || round_num !== 4'd0 || round_key !== 128'h0) begin
            miscompares++;
            $display("FAIL idle_next: valid=%b num=%0d key=%h want 0 0 0",
                     key_valid, round_num, round_key);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_fips_key();
        test_hold_last();
        test_ascending_key();
        test_restart_in_sub();
        test_en_next_same();
        test_kill_upd();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
